// File: rtl/johnson_phase_monitor.sv
// Johnson counter phase monitor: decodes the counter state into a phase index and one-hot strobe,
// tracks successor continuity, reports lock and a saturating error count. Optional macro: JOHNSON_DIR_EN.
module johnson_phase_monitor #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_W      = 8
) (
    input  logic                          clk,
    input  logic                          clear,
    input  logic [WIDTH-1:0]              johnson_in,
    input  logic                          valid_in,
    output logic [$clog2(2*WIDTH)-1:0]    phase,
    output logic [2*WIDTH-1:0]            onehot,
    output logic                          phase_valid,
    output logic                          illegal,
    output logic                          seq_err,
    output logic                          locked,
    output logic [ERR_W-1:0]              err_count,
`ifdef JOHNSON_DIR_EN
    output logic                          dir,
`endif
    output logic [1:0]                    dbg_state
);

    localparam int N     = 2 * WIDTH;
    localparam int PW    = $clog2(N);
    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0] ONES = '1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        TRACK    = 2'd1,
        LOCKED   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [PW-1:0]      prev_q, prev_d;
    logic [PW-1:0]      phase_q, phase_d;
    logic [N-1:0]       onehot_q, onehot_d;
    logic               pv_q, pv_d;
    logic               illegal_q, illegal_d;
    logic               seq_err_q, seq_err_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               dir_q, dir_d;

    logic               legal;
    logic [PW-1:0]      dec;
    logic               is_fwd, is_rev, step_ok;
    logic [RUN_W-1:0]   run_inc;

    function automatic logic [PW-1:0] succ(input logic [PW-1:0] p);
        succ = (p == PW'(N - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] pred(input logic [PW-1:0] p);
        pred = (p == '0) ? PW'(N - 1) : p - 1'b1;
    endfunction

    // Leading run of k ones gives phase k; leading zeros then k trailing ones gives phase N-k.
    always_comb begin
        legal = 1'b0;
        dec   = '0;
        for (int k = 0; k <= WIDTH; k++) begin
            if (johnson_in == ~(ONES >> k)) begin
                legal = 1'b1;
                dec   = PW'(k);
            end
        end
        for (int k = 1; k < WIDTH; k++) begin
            if (johnson_in == (ONES >> (WIDTH - k))) begin
                legal = 1'b1;
                dec   = PW'(N - k);
            end
        end
    end

    always_comb begin
        is_fwd  = (dec == succ(prev_q));
        is_rev  = (dec == pred(prev_q));
        step_ok = 1'b0;
`ifdef JOHNSON_DIR_EN
        // The first tracked step may go either way; afterwards the latched direction rules.
        if (state_q == TRACK && run_q == '0) step_ok = is_fwd || is_rev;
        else                                 step_ok = dir_q ? is_rev : is_fwd;
`else
        step_ok = is_fwd;
`endif
    end

    assign run_inc = run_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        prev_d    = prev_q;
        dir_d     = dir_q;
        phase_d   = phase_q;
        onehot_d  = '0;
        pv_d      = 1'b0;
        illegal_d = 1'b0;
        seq_err_d = 1'b0;
        err_d     = err_q;
        if (valid_in) begin
            if (legal) begin
                phase_d  = dec;
                onehot_d = N'(1) << dec;
                pv_d     = 1'b1;
                prev_d   = dec;
            end else begin
                illegal_d = 1'b1;
            end
            case (state_q)
                UNLOCKED: begin
                    if (legal) begin
                        run_d   = '0;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (!legal) begin
                        run_d   = '0;
                        state_d = UNLOCKED;
                    end else if (step_ok) begin
                        run_d = run_inc;
                        if (run_q == '0) dir_d = is_rev && !is_fwd;
                        if (run_inc == RUN_W'(LOCK_COUNT)) state_d = LOCKED;
                    end else begin
                        run_d = '0;
                    end
                end
                LOCKED: begin
                    if (!legal || !step_ok) begin
                        seq_err_d = 1'b1;
                        run_d     = '0;
                        state_d   = UNLOCKED;
                        if (err_q != '1) err_d = err_q + 1'b1;
                    end
                end
                default: begin
                    run_d   = '0;
                    state_d = UNLOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q   <= UNLOCKED;
            run_q     <= '0;
            prev_q    <= '0;
            dir_q     <= 1'b0;
            phase_q   <= '0;
            onehot_q  <= '0;
            pv_q      <= 1'b0;
            illegal_q <= 1'b0;
            seq_err_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            prev_q    <= prev_d;
            dir_q     <= dir_d;
            phase_q   <= phase_d;
            onehot_q  <= onehot_d;
            pv_q      <= pv_d;
            illegal_q <= illegal_d;
            seq_err_q <= seq_err_d;
            err_q     <= err_d;
        end
    end

    assign phase       = phase_q;
    assign onehot      = onehot_q;
    assign phase_valid = pv_q;
    assign illegal     = illegal_q;
    assign seq_err     = seq_err_q;
    assign locked      = (state_q == LOCKED);
    assign err_count   = err_q;
    assign dbg_state   = state_q;
`ifdef JOHNSON_DIR_EN
    assign dir         = dir_q;
`else
    logic unused_dir;
    assign unused_dir = dir_q;
`endif

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Scoreboard bench for johnson_phase_monitor: directed Johnson sequences with hand-computed
// expectations queued by the driver and popped by a negedge monitor.
module tb_johnson_phase_monitor;

    localparam int EW = 23;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic [3:0]  johnson_in = 4'b0000;
    logic        valid_in = 1'b0;
    logic [2:0]  phase;
    logic [7:0]  onehot;
    logic        phase_valid, illegal, seq_err, locked;
    logic [7:0]  err_count;
    logic [1:0]  dbg_state;
`ifdef JOHNSON_DIR_EN
    logic        dir;
`endif

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp, mon_act;
    int n_vec = 0;
    int n_err = 0;
    int ec_m;

    johnson_phase_monitor #(.WIDTH(4), .LOCK_COUNT(3), .ERR_W(8)) dut (
        .clk         (clk),
        .clear       (clear),
        .johnson_in  (johnson_in),
        .valid_in    (valid_in),
        .phase       (phase),
        .onehot      (onehot),
        .phase_valid (phase_valid),
        .illegal     (illegal),
        .seq_err     (seq_err),
        .locked      (locked),
        .err_count   (err_count),
`ifdef JOHNSON_DIR_EN
        .dir         (dir),
`endif
        .dbg_state   (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // driver: one valid sample per cycle; expected outputs pushed with it
    task automatic put(input logic [3:0] code, input logic [2:0] ph, input logic ill,
                       input logic se, input logic lk, input logic [7:0] ec);
        logic [7:0] oh;
        oh = ill ? 8'h00 : (8'h01 << ph);
        @(posedge clk); #1;
        johnson_in = code;
        valid_in   = 1'b1;
        exp_q.push_back({ph, oh, ~ill, ill, se, lk, ec});
    endtask

    task automatic drain();
        @(posedge clk); #1;
        valid_in = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clk); #1;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // monitor: pop and compare whenever the DUT presents a sample result
    always @(negedge clk) begin
        mon_act = {phase, onehot, phase_valid, illegal, seq_err, locked, err_count};
        if (phase_valid || illegal) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output got=%h exp=none", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    n_err++;
                    $display("FAIL sample got=%h exp=%h", mon_act, mon_exp);
                end
            end
        end else begin
            n_vec++;
            if (onehot !== 8'h00 || seq_err !== 1'b0) begin
                n_err++;
                $display("FAIL idle_outputs got onehot=%h seq_err=%b exp onehot=00 seq_err=0",
                         onehot, seq_err);
            end
        end
    end

    initial begin
        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_onehot", 32'(onehot), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_flags", 32'({phase_valid, illegal, seq_err}), 0);
        @(posedge clk); #1;
        clear = 1'b0;

        // free-running forward sequence, lock after 3rd correct step, wrap 7->0
        put(4'b0000, 0, 0, 0, 0, 0);
        put(4'b1000, 1, 0, 0, 0, 0);
        put(4'b1100, 2, 0, 0, 0, 0);
        put(4'b1110, 3, 0, 0, 1, 0);
        put(4'b1111, 4, 0, 0, 1, 0);
        put(4'b0111, 5, 0, 0, 1, 0);
        put(4'b0011, 6, 0, 0, 1, 0);
        put(4'b0001, 7, 0, 0, 1, 0);
        put(4'b0000, 0, 0, 0, 1, 0);
        put(4'b1000, 1, 0, 0, 1, 0);
        // illegal while locked, then relock
        put(4'b1010, 1, 1, 1, 0, 1);
        put(4'b1100, 2, 0, 0, 0, 1);
        put(4'b1110, 3, 0, 0, 0, 1);
        put(4'b1111, 4, 0, 0, 0, 1);
        put(4'b0111, 5, 0, 0, 1, 1);
        put(4'b0011, 6, 0, 0, 1, 1);
        put(4'b0001, 7, 0, 0, 1, 1);
        put(4'b0000, 0, 0, 0, 1, 1);
        put(4'b1000, 1, 0, 0, 1, 1);
        // skip from phase 1 to phase 4 while locked
        put(4'b1111, 4, 0, 1, 0, 2);
        put(4'b0111, 5, 0, 0, 0, 2);
        put(4'b0011, 6, 0, 0, 0, 2);
        put(4'b0001, 7, 0, 0, 0, 2);
        put(4'b0000, 0, 0, 0, 1, 2);
        put(4'b1000, 1, 0, 0, 1, 2);

        // valid_in gap while locked
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
            @(negedge clk);
            chk("gap_locked", 32'(locked), 1);
            chk("gap_phase_hold", 32'(phase), 1);
        end
        put(4'b1100, 2, 0, 0, 1, 2);
        put(4'b1110, 3, 0, 0, 1, 2);

        // wrong legal phase in TRACK restarts without seq_err
        put(4'b1010, 3, 1, 1, 0, 3);
        put(4'b0000, 0, 0, 0, 0, 3);
        put(4'b1000, 1, 0, 0, 0, 3);
        put(4'b0011, 6, 0, 0, 0, 3);
        put(4'b0001, 7, 0, 0, 0, 3);
        put(4'b0000, 0, 0, 0, 0, 3);
        put(4'b1000, 1, 0, 0, 1, 3);
        // illegal in LOCKED, UNLOCKED and TRACK
        put(4'b0110, 1, 1, 1, 0, 4);
        put(4'b1001, 1, 1, 0, 0, 4);
        put(4'b0000, 0, 0, 0, 0, 4);
        put(4'b0100, 0, 1, 0, 0, 4);
        put(4'b1000, 1, 0, 0, 0, 4);
        put(4'b1100, 2, 0, 0, 0, 4);
        put(4'b1110, 3, 0, 0, 0, 4);
        put(4'b1111, 4, 0, 0, 1, 4);

        // repeated seq_err events until err_count saturates
        ec_m = 4;
        for (int i = 0; i < 255; i++) begin
            ec_m = (ec_m == 255) ? 255 : ec_m + 1;
            put(4'b0000, 0, 0, 1, 0, 8'(ec_m));
            put(4'b1000, 1, 0, 0, 0, 8'(ec_m));
            put(4'b1100, 2, 0, 0, 0, 8'(ec_m));
            put(4'b1110, 3, 0, 0, 0, 8'(ec_m));
            put(4'b1111, 4, 0, 0, 1, 8'(ec_m));
        end
        drain();
        chk("err_saturated", 32'(err_count), 255);
        chk("locked_before_clear", 32'(locked), 1);

        // clear mid-stream
        @(posedge clk); #1;
        johnson_in = 4'b0111;
        valid_in   = 1'b1;
        clear      = 1'b1;
        #1;
        chk("clr_err_count", 32'(err_count), 0);
        chk("clr_locked", 32'(locked), 0);
        chk("clr_phase", 32'(phase), 0);
        chk("clr_onehot", 32'(onehot), 0);
        chk("clr_flags", 32'({phase_valid, illegal, seq_err}), 0);
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(posedge clk); #1;
        clear = 1'b0;

`ifdef JOHNSON_DIR_EN
        chk("clr_dir", 32'(dir), 0);
        put(4'b0000, 0, 0, 0, 0, 0);
        put(4'b0001, 7, 0, 0, 0, 0);
        put(4'b0011, 6, 0, 0, 0, 0);
        put(4'b0111, 5, 0, 0, 1, 0);
        drain();
        chk("rev_dir", 32'(dir), 1);
        chk("rev_locked", 32'(locked), 1);
`else
        put(4'b0000, 0, 0, 0, 0, 0);
        put(4'b1000, 1, 0, 0, 0, 0);
        put(4'b1100, 2, 0, 0, 0, 0);
        put(4'b1110, 3, 0, 0, 1, 0);
        drain();
        chk("relock_after_clear", 32'(locked), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
